// File: rtl/bias_fetch_pkg.sv
// Shared types and helpers for the bias fetch sequencer.
// Define BIAS_FETCH_PREFETCH_EN for a 2-word buffer that reads ahead while the current word drains.
package bias_fetch_pkg;

`ifdef BIAS_FETCH_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } bias_fetch_state_t;

  function automatic int lanes(input int word_w, input int bias_w);
    return word_w / bias_w;
  endfunction

  function automatic int words_for(input int n, input int lanes_per_word);
    return (n + lanes_per_word - 1) / lanes_per_word;
  endfunction

endpackage

// File: rtl/bias_word_fifo.sv
// Small shift-style word FIFO (1 or 2 entries); entry 0 is always the head.
module bias_word_fifo
  import bias_fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [DEPTH];
  logic [1:0]   wr_idx;

  // A same-cycle pop shifts first, so the new word lands one slot lower.
  assign wr_idx = count - {1'b0, pop};
  assign head   = mem[0];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_idx == 2'(i)) mem[i] <= din;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/bias_fetch_sequencer.sv
// Reads packed bias rows from the bias memory and streams them out one lane per handshake.
// Build option BIAS_FETCH_PREFETCH_EN (see bias_fetch_pkg) only changes throughput.
module bias_fetch_sequencer
  import bias_fetch_pkg::*;
#(
  parameter int BIAS_WORD_BIT_WIDTH = 64,
  parameter int BIAS_ROWS           = 32,
  parameter int BIAS_BIT_WIDTH      = 16,
  parameter int COUNT_W             = 12,
  parameter int ADDR_W              = $clog2(BIAS_ROWS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_W-1:0]              start_address,
  input  logic [COUNT_W-1:0]             num_biases,
  input  logic                           global_power_down,
  output logic                           bias_control_chip_select,
  output logic                           bias_control_write_enable,
  output logic [ADDR_W-1:0]              bias_control_address,
  output logic [BIAS_WORD_BIT_WIDTH-1:0] bias_control_data_in,
  output logic [BIAS_WORD_BIT_WIDTH-1:0] bias_control_mask,
  input  logic [BIAS_WORD_BIT_WIDTH-1:0] bias_data_out,
  output logic                           bias_valid,
  input  logic                           bias_ready,
  output logic [BIAS_BIT_WIDTH-1:0]      bias_value,
  output logic                           bias_last,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     fsm_state
);

  localparam int LANES  = lanes(BIAS_WORD_BIT_WIDTH, BIAS_BIT_WIDTH);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(BIAS_ROWS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  bias_fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0]              addr_q;
  logic [COUNT_W-1:0]             words_left_q;
  logic [COUNT_W-1:0]             num_q;
  logic [COUNT_W-1:0]             idx_q;
  logic [LANE_W-1:0]              lane_q;
  logic                           inflight_q;
  logic                           done_q;
  logic [1:0]                     fifo_count;
  logic [BIAS_WORD_BIT_WIDTH-1:0] fifo_head;
  logic [2:0]                     occupancy;
  logic                           accept, issue, hs, is_last, word_end, push, pop;
  logic [BIAS_BIT_WIDTH-1:0]      lane_vals [LANES];

  assign accept    = (state_q == IDLE) && start && !abort;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue     = (state_q == FETCH) && (words_left_q != '0) &&
                     (occupancy < 3'(BUF_DEPTH)) && !global_power_down && !abort;

  // Output handshake: a bias transfers on a rising edge with bias_valid && bias_ready;
  // once bias_valid rises, it and the payload hold until that transfer (or an abort).
  assign bias_valid = (fifo_count != 2'd0);
  assign hs         = bias_valid && bias_ready;
  assign is_last    = (idx_q == num_q - COUNT_W'(1));
  assign word_end   = (lane_q == LAST_LANE) || is_last;
  assign push       = inflight_q && !abort;
  assign pop        = hs && word_end && !abort;
  assign bias_last  = bias_valid && is_last;

  always_comb begin
    for (int i = 0; i < LANES; i++) lane_vals[i] = fifo_head[i*BIAS_BIT_WIDTH +: BIAS_BIT_WIDTH];
  end
  assign bias_value = lane_vals[lane_q];

  assign bias_control_write_enable = 1'b0;
  assign bias_control_data_in      = '0;
  assign bias_control_mask         = '0;
  assign bias_control_address      = addr_q;
  assign done                      = done_q;

  bias_word_fifo #(
    .W     (BIAS_WORD_BIT_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .din   (bias_data_out),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && num_biases != '0) state_d = FETCH;
        FETCH:   if (issue && words_left_q == COUNT_W'(1)) state_d = DRAIN;
        DRAIN:   if (hs && is_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bias_control_chip_select = issue;
    busy                     = (state_q != IDLE);
    fsm_state                = 2'(state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      words_left_q <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else if (abort) begin
      words_left_q <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      inflight_q <= issue;
      // Zero-length jobs complete straight from IDLE without ever going busy.
      done_q     <= (accept && num_biases == '0) || (hs && is_last);
      if (accept) begin
        addr_q       <= start_address;
        words_left_q <= COUNT_W'(words_for(int'(num_biases), LANES));
        num_q        <= num_biases;
        idx_q        <= '0;
        lane_q       <= '0;
      end else begin
        if (issue) begin
          addr_q       <= (addr_q == LAST_ROW) ? '0 : addr_q + ADDR_W'(1);
          words_left_q <= words_left_q - COUNT_W'(1);
        end
        if (hs) begin
          idx_q  <= idx_q + COUNT_W'(1);
          lane_q <= word_end ? '0 : lane_q + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/bias_fetch_sequencer.md
# bias_fetch_sequencer

Drives the read side of the managed bias memory's control port and turns the returned packed bias words into a per-channel bias stream for the accumulator-initialisation logic. On `start` it reads `ceil(num_biases/LANES)` consecutive rows from `start_address` and buffers each word. It then emits one `BIAS_BIT_WIDTH` lane per valid/ready handshake, marking the final bias with `bias_last`.

## Interface
- `BIAS_WORD_BIT_WIDTH`, 64: bias memory word width.
- `BIAS_ROWS`, 32: bias memory depth; `ADDR_W = $clog2(BIAS_ROWS)`.
- `BIAS_BIT_WIDTH`, 16: one bias; `LANES = BIAS_WORD_BIT_WIDTH / BIAS_BIT_WIDTH`, must be an integer ≥ 1.
- `COUNT_W`, 12: width of `num_biases`.
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; ignored unless `busy`=0.
- `abort` in 1: synchronous cancel of the current job.
- `start_address` in `ADDR_W`: first row to read.
- `num_biases` in `COUNT_W`: number of biases to emit.
- `global_power_down` in 1: while high, no reads are issued.
- `bias_control_chip_select` out 1: memory read strobe.
- `bias_control_write_enable` out 1: tied 0.
- `bias_control_address` out `ADDR_W`: row to read.
- `bias_control_data_in` out `BIAS_WORD_BIT_WIDTH`: tied 0.
- `bias_control_mask` out `BIAS_WORD_BIT_WIDTH`: tied 0.
- `bias_data_out` in `BIAS_WORD_BIT_WIDTH`: memory read data, valid the cycle after a strobe.
- `bias_valid` out 1, `bias_ready` in 1: output handshake.
- `bias_value` out `BIAS_BIT_WIDTH`, `bias_last` out 1: payload.
- `busy` out 1: job in progress; `done` out 1: one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN when all reads are issued.
  - DRAIN → IDLE when the last bias is handshaken, pulsing `done`.
  - Any state → IDLE on `abort`: clears the buffer and counters, drops in-flight data, no `done`.
- `num_biases`=0: IDLE → IDLE, with `done` pulsed the next cycle and no reads issued.
- Read issue condition (FETCH): `words_left`>0 and buffer occupancy + in-flight < DEPTH and `!global_power_down` and `!abort`.
- When a read issues:
  - `bias_control_chip_select`=1 that cycle.
  - The address register increments modulo `BIAS_ROWS`, so `BIAS_ROWS-1` wraps to 0.
  - `words_left` decrements.
- The in-flight flag is set for one cycle. The following cycle `bias_data_out` is written into the buffer tail.
- Lane order:
  - Lane 0 = `bias_data_out[BIAS_BIT_WIDTH-1:0]`, emitted first.
  - A lane counter advances on each handshake.
  - The head word pops after lane `LANES-1`, or after the last bias.
- Partial final word: only `num_biases mod LANES` lanes are emitted; the remaining lanes are discarded.
- `bias_last` = 1 on the handshake that emits bias index `num_biases-1`.
- `bias_value` is held stable while `bias_valid`=1 and `bias_ready`=0.
- `global_power_down` mid-job only stalls issue. Buffered data still drains.

## Timing
- Reset: every output is 0.
- `start` high in cycle 0 gives:
  - cycle 1: first strobe.
  - cycle 2: data on `bias_data_out`, captured at the end of the cycle.
  - cycle 3: `bias_valid`=1.
- With `bias_ready` held high and prefetch enabled: one bias per cycle, with no bubbles between words.
- `done` is asserted in the cycle after the last handshake; `busy` drops in that same cycle.
- `start` coincident with `abort`: `abort` wins and `start` is ignored.

## Configuration
- `BIAS_FETCH_PREFETCH_EN` defined: DEPTH=2. The next word is read while the current word drains.
- Undefined: DEPTH=1. A read issues only when the buffer is empty with nothing in flight, giving a 2-cycle bubble per word when `bias_ready` is held high.
- All outputs and their ordering are identical in both builds; only throughput differs.

## Structure
- Package `bias_fetch_pkg`:
  - State enum `bias_fetch_state_t` (IDLE, FETCH, DRAIN).
  - `lanes()` and `words_for()` (ceil-divide) constant functions.
- Sub-module `bias_word_fifo`: DEPTH-entry (1 or 2) word FIFO with push, pop, count and head.

## Test plan
- `start_address`=3, `num_biases`=8, LANES=4, `bias_ready`=1: exactly 2 strobes at addresses 3 and 4. Biases emitted in lane order; `bias_last` on the 8th; `done` one cycle later.
- `start_address`=31, `num_biases`=9: reads at 31, 0, 1 (wrap). Only lane 0 of the third word is emitted.
- `num_biases`=0: no strobe; `done` pulses in cycle 1; `busy` never rises.
- `bias_ready` toggled pseudo-randomly: `bias_value` stable while stalled; output sequence equals the scoreboard; strobes never exceed buffer space.
- `global_power_down` high for 5 cycles mid-FETCH: no strobe during those cycles; buffered biases still drain; the job completes with the correct data.
- `abort` while a read is in flight: state returns to IDLE next cycle; `bias_valid`=0; no `done`. A subsequent `start` runs cleanly.
